dmm_region_alloc: RTL and testbench



---
 rtl/dmm_region_alloc_if.sv | 45 ++++
 rtl/dmm_region_alloc.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dmm_region_alloc.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmm_region_alloc_if.sv
// ---------------------------------------------------------------------------
// dmm_region_alloc_if
//
// Request/response bundle between a requesting processor and the
// dmm_region_alloc region allocator.
//
//   malloc      requester -> allocator  allocate request
//   free        requester -> allocator  release request
//   req_size    requester -> allocator  words requested (malloc)
//   req_tag     requester -> allocator  tag to bind (malloc) or release (free)
//   busy        allocator -> requester  request in flight
//   mack        allocator -> requester  one-cycle malloc completion pulse
//   frack       allocator -> requester  one-cycle free completion pulse
//   merr        allocator -> requester  malloc failed, valid with mack
//   ferr        allocator -> requester  free failed, valid with frack
//   alloc_addr  allocator -> requester  granted base address, held until next mack
//
// Modports: master = requester side, slave = allocator side.
// ---------------------------------------------------------------------------
interface dmm_region_alloc_if #(
    parameter int SIZE_W = 7,
    parameter int TAG_W  = 3,
    parameter int ADDR_W = 9
);
    logic              malloc;
    logic              free;
    logic [SIZE_W-1:0] req_size;
    logic [TAG_W-1:0]  req_tag;
    logic              busy;
    logic              mack;
    logic              frack;
    logic              merr;
    logic              ferr;
    logic [ADDR_W-1:0] alloc_addr;

    modport master (
        output malloc, free, req_size, req_tag,
        input  busy, mack, frack, merr, ferr, alloc_addr
    );

    modport slave (
        input  malloc, free, req_size, req_tag,
        output busy, mack, frack, merr, ferr, alloc_addr
    );
endinterface

// File: rtl/dmm_region_alloc.sv
// ---------------------------------------------------------------------------
// dmm_region_alloc
//
// Region allocator for dynamic memory management. Serves malloc/free
// requests against NUM_REGIONS equal regions of a flat address space using
// a bump pointer per region. Each live allocation is bound to a requester
// tag so a free needs only the tag. Space is reclaimed when the top-most
// allocation of a region is freed, or when the region's live count drops
// to zero.
//
// Ports:
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-low reset
//   bus    dmm_region_alloc_if.slave (malloc/free/req_size/req_tag in,
//          busy/mack/frack/merr/ferr/alloc_addr out)
//
// Build option:
//   DMM_BEST_FIT_EN  defined   -> best fit (smallest remaining that fits,
//                                 ties to the lowest region index)
//                    undefined -> first fit (lowest region index that fits)
//   Latency is identical in both builds.
//
// Request flow: IDLE -> SEARCH -> COMMIT -> RESP -> IDLE. The ack pulse is
// registered out of RESP, so it appears in the cycle the FSM is back in
// IDLE; busy stays high through that cycle and a new request is accepted
// on the edge that ends it.
// ---------------------------------------------------------------------------
module dmm_region_alloc #(
    parameter int NUM_REGIONS  = 6,
    parameter int REGION_WORDS = 64,
    parameter int NUM_TAGS     = 8
) (
    input  logic                clk,
    input  logic                reset,
    dmm_region_alloc_if.slave   bus
);

    localparam int ADDR_W = $clog2(NUM_REGIONS * REGION_WORDS);
    localparam int SIZE_W = $clog2(REGION_WORDS + 1);
    localparam int TAG_W  = $clog2(NUM_TAGS);
    localparam int REG_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int LIVE_W = $clog2(NUM_TAGS + 1);

    localparam logic [SIZE_W-1:0] RW = SIZE_W'(REGION_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_COMMIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    // Latched request
    logic              op_malloc_q;
    logic [SIZE_W-1:0] size_q;
    logic [TAG_W-1:0]  tag_q;

    // Registered search result
    logic              sel_err_q;
    logic [REG_W-1:0]  sel_region_q;
    logic [ADDR_W-1:0] sel_addr_q;

    // Per-region state
    logic [SIZE_W-1:0] ptr_q  [NUM_REGIONS];
    logic [LIVE_W-1:0] live_q [NUM_REGIONS];

    // Per-tag state
    logic              tag_valid_q  [NUM_TAGS];
    logic [REG_W-1:0]  tag_region_q [NUM_TAGS];
    logic [SIZE_W-1:0] tag_off_q    [NUM_TAGS];
    logic [SIZE_W-1:0] tag_size_q   [NUM_TAGS];

    // Output registers
    logic              busy_q;
    logic              mack_q;
    logic              frack_q;
    logic              merr_q;
    logic              ferr_q;
    logic [ADDR_W-1:0] addr_q;

    logic accept;
    assign accept = (state_q == S_IDLE) && (bus.malloc || bus.free);

    // ------------------------------------------------------------------
    // Region search over the latched size
    // ------------------------------------------------------------------
    logic              fit_found;
    logic [REG_W-1:0]  fit_region;
    logic [ADDR_W-1:0] fit_addr;
    logic [SIZE_W-1:0] rem_c;
`ifdef DMM_BEST_FIT_EN
    logic [SIZE_W-1:0] fit_rem;
`endif

    always_comb begin
        fit_found  = 1'b0;
        fit_region = '0;
        fit_addr   = '0;
        rem_c      = '0;
`ifdef DMM_BEST_FIT_EN
        fit_rem    = '0;
`endif
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            rem_c = RW - ptr_q[i];
`ifdef DMM_BEST_FIT_EN
            // Strict '<' keeps the lowest index on equal remaining space.
            if ((rem_c >= size_q) && (!fit_found || (rem_c < fit_rem))) begin
                fit_found  = 1'b1;
                fit_region = REG_W'(i);
                fit_rem    = rem_c;
                fit_addr   = ADDR_W'(i * REGION_WORDS) + ADDR_W'(ptr_q[i]);
            end
`else
            if ((rem_c >= size_q) && !fit_found) begin
                fit_found  = 1'b1;
                fit_region = REG_W'(i);
                fit_addr   = ADDR_W'(i * REGION_WORDS) + ADDR_W'(ptr_q[i]);
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Tag lookup and error qualification
    // ------------------------------------------------------------------
    logic              tag_in_range;
    logic              tag_cur_valid;
    logic [REG_W-1:0]  fr_region;
    logic [SIZE_W-1:0] fr_off;
    logic [SIZE_W-1:0] fr_size;
    logic              malloc_err;
    logic              free_err;
    logic              search_err;

    always_comb begin
        tag_in_range  = 32'(tag_q) < 32'(NUM_TAGS);
        tag_cur_valid = 1'b0;
        fr_region     = '0;
        fr_off        = '0;
        fr_size       = '0;
        if (tag_in_range) begin
            tag_cur_valid = tag_valid_q[tag_q];
            fr_region     = tag_region_q[tag_q];
            fr_off        = tag_off_q[tag_q];
            fr_size       = tag_size_q[tag_q];
        end
        malloc_err = (size_q == '0) || (size_q > RW) || !tag_in_range
                     || tag_cur_valid || !fit_found;
        free_err   = !tag_cur_valid;
        search_err = op_malloc_q ? malloc_err : free_err;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_SEARCH;
            S_SEARCH: state_d = S_COMMIT;
            S_COMMIT: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, tables and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_malloc_q  <= 1'b0;
            size_q       <= '0;
            tag_q        <= '0;
            sel_err_q    <= 1'b0;
            sel_region_q <= '0;
            sel_addr_q   <= '0;
            busy_q       <= 1'b0;
            mack_q       <= 1'b0;
            frack_q      <= 1'b0;
            merr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            addr_q       <= '0;
            for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
                ptr_q[r]  <= '0;
                live_q[r] <= '0;
            end
            for (int unsigned t = 0; t < NUM_TAGS; t++) begin
                tag_valid_q[t]  <= 1'b0;
                tag_region_q[t] <= '0;
                tag_off_q[t]    <= '0;
                tag_size_q[t]   <= '0;
            end
        end else begin
            mack_q  <= 1'b0;
            frack_q <= 1'b0;
            merr_q  <= 1'b0;
            ferr_q  <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    // busy also covers the ack cycle and drops at its end
                    // unless a new request is taken on that same edge.
                    busy_q <= accept;
                    if (accept) begin
                        // malloc wins when both are asserted; free is dropped
                        op_malloc_q <= bus.malloc;
                        size_q      <= bus.req_size;
                        tag_q       <= bus.req_tag;
                    end
                end

                S_SEARCH: begin
                    sel_err_q    <= search_err;
                    sel_region_q <= fit_region;
                    sel_addr_q   <= fit_addr;
                end

                S_COMMIT: begin
                    if (!sel_err_q) begin
                        if (op_malloc_q) begin
                            tag_valid_q[tag_q]    <= 1'b1;
                            tag_region_q[tag_q]   <= sel_region_q;
                            tag_off_q[tag_q]      <= ptr_q[sel_region_q];
                            tag_size_q[tag_q]     <= size_q;
                            ptr_q[sel_region_q]   <= ptr_q[sel_region_q] + size_q;
                            live_q[sel_region_q]  <= live_q[sel_region_q] + LIVE_W'(1);
                        end else begin
                            tag_valid_q[tag_q] <= 1'b0;
                            live_q[fr_region]  <= live_q[fr_region] - LIVE_W'(1);
                            if (live_q[fr_region] == LIVE_W'(1)) begin
                                ptr_q[fr_region] <= '0;
                            end else if ((fr_off + fr_size) == ptr_q[fr_region]) begin
                                ptr_q[fr_region] <= fr_off;
                            end
                        end
                    end
                end

                S_RESP: begin
                    mack_q  <= op_malloc_q;
                    frack_q <= !op_malloc_q;
                    merr_q  <= op_malloc_q && sel_err_q;
                    ferr_q  <= !op_malloc_q && sel_err_q;
                    if (op_malloc_q && !sel_err_q) begin
                        addr_q <= sel_addr_q;
                    end
                end

                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.mack       = mack_q;
    assign bus.frack      = frack_q;
    assign bus.merr       = merr_q;
    assign bus.ferr       = ferr_q;
    assign bus.alloc_addr = addr_q;

endmodule

// File: tb/tb_dmm_region_alloc.sv
// ---------------------------------------------------------------------------
// tb_dmm_region_alloc
//
// Directed bench for dmm_region_alloc with the default geometry
// (6 regions x 64 words, 8 tags). Expected addresses are hand-computed;
// the few that depend on the fit policy follow DMM_BEST_FIT_EN.
// ---------------------------------------------------------------------------
module tb_dmm_region_alloc;

    localparam int NUM_REGIONS  = 6;
    localparam int REGION_WORDS = 64;
    localparam int NUM_TAGS     = 8;
    localparam int ADDR_W = $clog2(NUM_REGIONS * REGION_WORDS);
    localparam int SIZE_W = $clog2(REGION_WORDS + 1);
    localparam int TAG_W  = $clog2(NUM_TAGS);

`ifdef DMM_BEST_FIT_EN
    localparam logic [ADDR_W-1:0] EXP_T3 = 9'd124;
    localparam logic [ADDR_W-1:0] EXP_T5 = 9'd124;
    localparam logic [ADDR_W-1:0] EXP_T6 = 9'd124;
`else
    localparam logic [ADDR_W-1:0] EXP_T3 = 9'd30;
    localparam logic [ADDR_W-1:0] EXP_T5 = 9'd30;
    localparam logic [ADDR_W-1:0] EXP_T6 = 9'd5;
`endif

    logic clk;
    logic reset;

    dmm_region_alloc_if #(.SIZE_W(SIZE_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) bus ();

    dmm_region_alloc #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_WORDS(REGION_WORDS),
        .NUM_TAGS    (NUM_TAGS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Observations returned by do_op
    bit                gm, gf, er, b1, pq;
    logic [ADDR_W-1:0] ad;
    int                lt;

    // Drive one request, hold it until an ack is seen, then observe the
    // cycle after the ack.
    task automatic do_op(input bit m, input bit f, input int sz, input int tg);
        @(negedge clk);
        bus.malloc   = m;
        bus.free     = f;
        bus.req_size = SIZE_W'(sz);
        bus.req_tag  = TAG_W'(tg);
        gm = 1'b0; gf = 1'b0; er = 1'b0; b1 = 1'b0; pq = 1'b0; ad = '0; lt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) b1 = bus.busy;
            if (bus.mack || bus.frack) begin
                gm = bus.mack;
                gf = bus.frack;
                er = bus.mack ? bus.merr : bus.ferr;
                ad = bus.alloc_addr;
                lt = i;
                break;
            end
        end
        bus.malloc = 1'b0;
        bus.free   = 1'b0;
        if (lt == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: no ack within 20 cycles (malloc=%0b free=%0b tag=%0d)", m, f, tg);
        end
        @(negedge clk);
        pq = !bus.mack && !bus.frack && !bus.busy;
    endtask

    task automatic apply_reset();
        bus.malloc   = 1'b0;
        bus.free     = 1'b0;
        bus.req_size = '0;
        bus.req_tag  = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({bus.busy, bus.mack, bus.frack, bus.merr, bus.ferr} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy/mack/frack/merr/ferr=%b, want 00000",
                     {bus.busy, bus.mack, bus.frack, bus.merr, bus.ferr});
        end
        vectors++;
        if (bus.alloc_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: alloc_addr=%0d, want 0", bus.alloc_addr);
        end
    endtask

    task automatic test_address_stacking();
        do_op(1, 0, 10, 0);
        vectors++;
        if (lt !== 4 || b1 !== 1'b1 || pq !== 1'b1) begin
            miscompares++;
            $display("FAIL timing: ack_latency=%0d busy_after_N=%0b quiet_after_ack=%0b, want 4/1/1", lt, b1, pq);
        end
        vectors++;
        if (gm !== 1'b1 || gf !== 1'b0 || er !== 1'b0 || ad !== 9'd0) begin
            miscompares++;
            $display("FAIL stack_t0: mack=%0b frack=%0b merr=%0b addr=%0d, want 1/0/0/0", gm, gf, er, ad);
        end
        do_op(1, 0, 20, 1);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b0 || ad !== 9'd10) begin
            miscompares++;
            $display("FAIL stack_t1: mack=%0b merr=%0b addr=%0d, want 1/0/10", gm, er, ad);
        end
    endtask

    task automatic test_fit_policy();
        do_op(1, 0, 60, 2);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b0 || ad !== 9'd64) begin
            miscompares++;
            $display("FAIL spill_t2: mack=%0b merr=%0b addr=%0d, want 1/0/64", gm, er, ad);
        end
        do_op(1, 0, 4, 3);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b0 || ad !== EXP_T3) begin
            miscompares++;
            $display("FAIL fit_t3: mack=%0b merr=%0b addr=%0d, want 1/0/%0d", gm, er, ad, EXP_T3);
        end
    endtask

    task automatic test_top_reclaim();
        do_op(0, 1, 0, 3);
        vectors++;
        if (gf !== 1'b1 || gm !== 1'b0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL free_t3: frack=%0b mack=%0b ferr=%0b, want 1/0/0", gf, gm, er);
        end
        // probe the reclaimed pointer, then give the probe back
        do_op(1, 0, 2, 5);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b0 || ad !== EXP_T5) begin
            miscompares++;
            $display("FAIL reclaim_probe: mack=%0b merr=%0b addr=%0d, want 1/0/%0d", gm, er, ad, EXP_T5);
        end
        do_op(0, 1, 0, 5);
        do_op(0, 1, 0, 1);
        vectors++;
        if (gf !== 1'b1 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL free_t1: frack=%0b ferr=%0b, want 1/0", gf, er);
        end
        do_op(0, 1, 0, 0);
        vectors++;
        if (gf !== 1'b1 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL free_t0: frack=%0b ferr=%0b, want 1/0", gf, er);
        end
        do_op(1, 0, 5, 4);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b0 || ad !== 9'd0) begin
            miscompares++;
            $display("FAIL drained_t4: mack=%0b merr=%0b addr=%0d, want 1/0/0", gm, er, ad);
        end
    endtask

    task automatic test_errors();
        do_op(0, 1, 0, 5);
        vectors++;
        if (gf !== 1'b1 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL free_invalid: frack=%0b ferr=%0b, want 1/1", gf, er);
        end
        do_op(1, 0, 1, 4);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b1 || ad !== 9'd0) begin
            miscompares++;
            $display("FAIL malloc_dup_tag: mack=%0b merr=%0b held_addr=%0d, want 1/1/0", gm, er, ad);
        end
        do_op(1, 0, 0, 6);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL malloc_size0: mack=%0b merr=%0b, want 1/1", gm, er);
        end
        do_op(1, 0, 65, 6);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL malloc_size65: mack=%0b merr=%0b, want 1/1", gm, er);
        end
        do_op(1, 0, 1, 6);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b0 || ad !== EXP_T6) begin
            miscompares++;
            $display("FAIL after_errors: mack=%0b merr=%0b addr=%0d, want 1/0/%0d", gm, er, ad, EXP_T6);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int t = 0; t < 6; t++) begin
            do_op(1, 0, 64, t);
            vectors++;
            if (gm !== 1'b1 || er !== 1'b0 || ad !== ADDR_W'(t * 64)) begin
                miscompares++;
                $display("FAIL fill_t%0d: mack=%0b merr=%0b addr=%0d, want 1/0/%0d", t, gm, er, ad, t * 64);
            end
        end
        do_op(1, 0, 1, 6);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL full_malloc: mack=%0b merr=%0b, want 1/1", gm, er);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        do_op(1, 1, 3, 2);
        vectors++;
        if (gm !== 1'b1 || gf !== 1'b0 || er !== 1'b0 || ad !== 9'd0 || pq !== 1'b1) begin
            miscompares++;
            $display("FAIL both_req: mack=%0b frack=%0b merr=%0b addr=%0d quiet=%0b, want 1/0/0/0/1", gm, gf, er, ad, pq);
        end
        do_op(0, 1, 0, 2);
        vectors++;
        if (gf !== 1'b1 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL both_req_cleanup: frack=%0b ferr=%0b, want 1/0", gf, er);
        end
    endtask

    task automatic test_back_to_back();
        int n_mack;
        logic [ADDR_W-1:0] a_seen;
        n_mack = 0;
        a_seen = '1;
        @(negedge clk);
        bus.malloc = 1'b1; bus.req_size = SIZE_W'(4); bus.req_tag = TAG_W'(3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.mack) begin
                n_mack++;
                a_seen = bus.alloc_addr;
            end
            case (k)
                1: bus.malloc = 1'b0;
                2: begin bus.malloc = 1'b1; bus.req_tag = TAG_W'(4); end
                3: bus.malloc = 1'b0;
                default: ;
            endcase
        end
        vectors++;
        if (n_mack !== 1 || a_seen !== 9'd0) begin
            miscompares++;
            $display("FAIL busy_ignore: mack_count=%0d addr=%0d, want 1/0", n_mack, a_seen);
        end
        do_op(0, 1, 0, 4);
        vectors++;
        if (gf !== 1'b1 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_ignore_tag4: frack=%0b ferr=%0b, want 1/1", gf, er);
        end
    endtask

    task automatic test_reset_midop();
        int n_ack;
        n_ack = 0;
        @(negedge clk);
        bus.malloc = 1'b1; bus.req_size = SIZE_W'(7); bus.req_tag = TAG_W'(5);
        @(negedge clk);                 // SEARCH
        @(negedge clk);                 // COMMIT
        reset = 1'b0;
        bus.malloc = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.mack, bus.frack, bus.merr, bus.ferr} !== 5'b0 || bus.alloc_addr !== '0) begin
            miscompares++;
            $display("FAIL midop_reset_outs: flags=%b addr=%0d, want 00000/0",
                     {bus.busy, bus.mack, bus.frack, bus.merr, bus.ferr}, bus.alloc_addr);
        end
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.mack || bus.frack || bus.busy) n_ack++;
        end
        vectors++;
        if (n_ack !== 0) begin
            miscompares++;
            $display("FAIL midop_no_ack: active_cycles=%0d, want 0", n_ack);
        end
        do_op(1, 0, 8, 0);
        vectors++;
        if (gm !== 1'b1 || er !== 1'b0 || ad !== 9'd0) begin
            miscompares++;
            $display("FAIL midop_after: mack=%0b merr=%0b addr=%0d, want 1/0/0", gm, er, ad);
        end
        do_op(0, 1, 0, 5);
        vectors++;
        if (gf !== 1'b1 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_tag5: frack=%0b ferr=%0b, want 1/1", gf, er);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        bus.malloc   = 1'b0;
        bus.free     = 1'b0;
        bus.req_size = '0;
        bus.req_tag  = '0;
        test_reset();
        test_address_stacking();
        test_fit_policy();
        test_top_reclaim();
        test_errors();
        test_fill();
        test_contention();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
